// File: rtl/poly_pkg.sv
// Shared types and helpers for the Horner polynomial evaluator.
// Saturation and sign extension work on a wide container and are sliced by callers.
package poly_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam int     MAXW     = 128;
   localparam int     P_FRAC_W = 8;
   localparam longint ONE      = longint'(1) << P_FRAC_W;

   function automatic logic signed [MAXW-1:0] sext_fn(input logic [MAXW-1:0] v, input int w);
      logic signed [MAXW-1:0] t;
      t = $signed(v << (MAXW - w));
      return t >>> (MAXW - w);
   endfunction

   // Clamp s to the signed range of a w-bit value.
   function automatic logic signed [MAXW-1:0] sat_fn(input logic signed [MAXW-1:0] s, input int w);
      logic signed [MAXW-1:0] hi;
      logic signed [MAXW-1:0] lo;
      hi = (MAXW'(1) <<< (w - 1)) - MAXW'(1);
      lo = ~hi;
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

endpackage

// File: rtl/poly_mac_step.sv
// One combinational Horner step: next_acc = ((acc * x) >>> FRAC_W) + coef.
// POLY_SAT_EN selects saturation on overflow; otherwise the result wraps.
module poly_mac_step
   import poly_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int COEF_W = 32,
   parameter int OUT_W  = 64,
   parameter int FRAC_W = 8
) (
   input  logic signed [OUT_W-1:0]  acc,
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [COEF_W-1:0] coef,
   output logic signed [OUT_W-1:0]  next_acc,
   output logic                     ovf
);

   localparam int PW = OUT_W + DATA_W;

   logic signed [PW-1:0]   w_acc_e;
   logic signed [PW-1:0]   w_x_e;
   logic signed [PW-1:0]   w_p;
   logic signed [PW-1:0]   w_ps;
   logic signed [PW:0]     w_s;
   logic signed [MAXW-1:0] w_s_wide;
   logic signed [MAXW-1:0] w_s_sat;

   assign w_acc_e  = PW'(acc);
   assign w_x_e    = PW'(x);
   assign w_p      = w_acc_e * w_x_e;
   assign w_ps     = w_p >>> FRAC_W;
   assign w_s      = (PW+1)'(w_ps) + (PW+1)'(coef);

   // Any difference after clamping means s left the OUT_W range.
   assign w_s_wide = MAXW'(w_s);
   assign w_s_sat  = sat_fn(w_s_wide, OUT_W);
   assign ovf      = (w_s_sat != w_s_wide);

`ifdef POLY_SAT_EN
   assign next_acc = w_s_sat[OUT_W-1:0];
`else
   assign next_acc = w_s[OUT_W-1:0];
`endif

endmodule

// File: rtl/poly_horner_eval.sv
// Run-time programmable fixed-point polynomial evaluator (Horner, one MAC per cycle)
// with a start_func/func_done level handshake. Define POLY_SAT_EN for saturating steps.
module poly_horner_eval
   import poly_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int COEF_W = 32,
   parameter int OUT_W  = 64,
   parameter int FRAC_W = 8,
   parameter int DEG    = 4,
   parameter int AW     = $clog2(DEG + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start_func,
   input  logic signed [DATA_W-1:0] x_in,
   input  logic                     coef_we,
   input  logic [AW-1:0]            coef_addr,
   input  logic signed [COEF_W-1:0] coef_wdata,
   output logic signed [OUT_W-1:0]  y_out,
   output logic                     func_done,
   output logic                     busy,
   output logic                     overflow
);

   localparam logic [AW-1:0] LAST_CNT = AW'(DEG - 1);

   state_t                   r_state;
   logic signed [DATA_W-1:0] r_x;
   logic signed [OUT_W-1:0]  r_acc;
   logic [AW-1:0]            r_cnt;
   logic signed [COEF_W-1:0] r_coef [0:DEG];
   logic signed [OUT_W-1:0]  r_y;
   logic                     r_done;
   logic                     r_busy;
   logic                     r_ovf;

   logic signed [OUT_W-1:0]  w_next_acc;
   logic                     w_step_ovf;
   logic                     w_coef_wr;

   poly_mac_step #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .OUT_W  (OUT_W),
      .FRAC_W (FRAC_W)
   ) u_step (
      .acc      (r_acc),
      .x        (r_x),
      .coef     (r_coef[r_cnt]),
      .next_acc (w_next_acc),
      .ovf      (w_step_ovf)
   );

   // Coefficients are frozen while an evaluation is stepping through them.
   assign w_coef_wr = coef_we && (r_state != CALC) &&
                      ((AW+1)'(coef_addr) <= (AW+1)'(DEG));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_x     <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_y     <= '0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
         r_ovf   <= 1'b0;
         for (int k = 0; k <= DEG; k++) r_coef[k] <= '0;
      end else begin
         if (w_coef_wr) r_coef[coef_addr] <= coef_wdata;
         case (r_state)
            IDLE: begin
               if (start_func) begin
                  r_x     <= x_in;
                  r_acc   <= OUT_W'(sext_fn(MAXW'(r_coef[DEG]), COEF_W));
                  r_cnt   <= LAST_CNT;
                  r_ovf   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= CALC;
               end
            end
            CALC: begin
               r_acc <= w_next_acc;
               r_ovf <= r_ovf | w_step_ovf;
               if (r_cnt == '0) begin
                  r_y     <= w_next_acc;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DONE: begin
               if (!start_func) begin
                  r_done  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign y_out     = r_y;
   assign func_done = r_done;
   assign busy      = r_busy;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_poly_horner_eval.sv
// Self-checking bench for poly_horner_eval against a wide-integer Horner reference model.
module tb_poly_horner_eval;
   import poly_pkg::*;

   localparam int DATA_W = 32;
   localparam int COEF_W = 32;
   localparam int OUT_W  = 64;
   localparam int FRAC_W = 8;
   localparam int DEG    = 4;
   localparam int AW     = $clog2(DEG + 1);

   logic                     clk;
   logic                     rst_n;
   logic                     start_func;
   logic signed [DATA_W-1:0] x_in;
   logic                     coef_we;
   logic [AW-1:0]            coef_addr;
   logic signed [COEF_W-1:0] coef_wdata;
   logic signed [OUT_W-1:0]  y_out;
   logic                     func_done;
   logic                     busy;
   logic                     overflow;

   int n_run  = 0;
   int n_fail = 0;

   logic signed [COEF_W-1:0] m_coef [0:DEG];

   poly_horner_eval #(
      .DATA_W (DATA_W), .COEF_W (COEF_W), .OUT_W (OUT_W),
      .FRAC_W (FRAC_W), .DEG (DEG), .AW (AW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_func (start_func),
      .x_in       (x_in),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_wdata (coef_wdata),
      .y_out      (y_out),
      .func_done  (func_done),
      .busy       (busy),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Polynomial value by Horner's rule over unbounded (128-bit) integers,
   // with the result range-limited to OUT_W after every step.
   function automatic void model(input logic [DATA_W-1:0] x, output logic [OUT_W-1:0] y,
                                 output logic ovf);
      logic signed [127:0] acc, s, hi, lo, xs;
      hi  = (128'sd1 <<< (OUT_W - 1)) - 128'sd1;
      lo  = -hi - 128'sd1;
      xs  = 128'($signed(x));
      acc = 128'(m_coef[DEG]);
      ovf = 1'b0;
      for (int k = DEG - 1; k >= 0; k--) begin
         s = ((acc * xs) >>> FRAC_W) + 128'(m_coef[k]);
         if (s > hi || s < lo) begin
            ovf = 1'b1;
`ifdef POLY_SAT_EN
            acc = (s > hi) ? hi : lo;
`else
            acc = 128'($signed(s[OUT_W-1:0]));
`endif
         end else begin
            acc = s;
         end
      end
      y = acc[OUT_W-1:0];
   endfunction

   task automatic wr(input int addr, input logic [COEF_W-1:0] d);
      @(negedge clk);
      coef_we    = 1'b1;
      coef_addr  = AW'(addr);
      coef_wdata = d;
      @(negedge clk);
      coef_we = 1'b0;
      if (addr <= DEG) m_coef[addr] = d;
   endtask

   task automatic clear_coefs();
      for (int k = 0; k <= DEG; k++) wr(k, '0);
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 0; i < 20 && lat < 0; i++) begin
         @(negedge clk);
         if (func_done === 1'b1) lat = i;
      end
   endtask

   task automatic do_eval(input logic [DATA_W-1:0] x, output logic [OUT_W-1:0] y,
                          output logic ovf, output int lat);
      @(negedge clk);
      start_func = 1'b1;
      x_in       = x;
      wait_done(lat);
      y   = y_out;
      ovf = overflow;
      start_func = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_run++;
      if (y_out !== '0) begin n_fail++; $display("FAIL reset_y: got %h want 0", y_out); end
      n_run++;
      if (func_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", func_done); end
      n_run++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_run++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
   endtask

   task automatic test_basic();
      logic [OUT_W-1:0] y;
      logic ovf;
      int lat;
      wr(0, COEF_W'(ONE));
      wr(1, COEF_W'(2 * ONE));
      do_eval(32'h40, y, ovf, lat);
      n_run++;
      if (y !== 64'h180) begin n_fail++; $display("FAIL basic_y: got %h want 180", y); end
      n_run++;
      if (ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", ovf); end
      n_run++;
      if (lat !== DEG) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, DEG); end
      n_run++;
      if (func_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_drop: got %b want 0", func_done); end
   endtask

   task automatic test_negative();
      logic [OUT_W-1:0] y;
      logic ovf;
      int lat;
      clear_coefs();
      wr(2, COEF_W'(ONE));
      do_eval(32'hFFFFFE00, y, ovf, lat);
      n_run++;
      if (y !== 64'h400) begin n_fail++; $display("FAIL neg_square: got %h want 400", y); end
      wr(2, '0);
      wr(1, COEF_W'(ONE));
      do_eval(32'hFFFFFF80, y, ovf, lat);
      n_run++;
      if (y !== 64'hFFFF_FFFF_FFFF_FF80) begin
         n_fail++; $display("FAIL neg_linear: got %h want ffffffffffffff80", y);
      end
   endtask

   task automatic test_overflow();
      logic [OUT_W-1:0] y, ey;
      logic ovf, eovf;
      int lat;
      clear_coefs();
      wr(4, 32'h7FFFFF00);
      model(32'h7FFFFF00, ey, eovf);
      do_eval(32'h7FFFFF00, y, ovf, lat);
      n_run++;
      if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ovf); end
      n_run++;
      if (y !== ey) begin n_fail++; $display("FAIL ovf_model_y: got %h want %h", y, ey); end
`ifdef POLY_SAT_EN
      n_run++;
      if (y !== 64'h7FFF_FFFF_FFFF_FFFF) begin
         n_fail++; $display("FAIL ovf_sat_y: got %h want 7fffffffffffffff", y);
      end
`endif
   endtask

   task automatic test_abort();
      logic [OUT_W-1:0] y;
      logic ovf;
      int lat;
      wr(0, COEF_W'(3 * ONE));
      @(negedge clk);
      start_func = 1'b1;
      x_in       = 32'h180;
      @(posedge clk);
      @(posedge clk);
      #1;
      n_run++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b want 1", busy); end
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_run++;
      if ({y_out, func_done, busy, overflow} !== '0) begin
         n_fail++;
         $display("FAIL abort_async_clear: got y=%h done=%b busy=%b ovf=%b want all 0",
                  y_out, func_done, busy, overflow);
      end
      start_func = 1'b0;
      for (int k = 0; k <= DEG; k++) m_coef[k] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      do_eval(32'h1234, y, ovf, lat);
      n_run++;
      if (y !== '0 || ovf !== 1'b0) begin
         n_fail++; $display("FAIL abort_zero_eval: got y=%h ovf=%b want 0/0", y, ovf);
      end
   endtask

   task automatic test_coef_write();
      logic [OUT_W-1:0] y;
      logic ovf;
      int lat;
      int bad;
      wr(1, COEF_W'(ONE));
      @(negedge clk);
      start_func = 1'b1;
      x_in       = 32'h200;
      @(negedge clk);
      coef_we    = 1'b1;
      coef_addr  = '0;
      coef_wdata = 32'h500;
      @(negedge clk);
      coef_we = 1'b0;
      wait_done(lat);
      n_run++;
      if (y_out !== 64'h200) begin n_fail++; $display("FAIL calc_write_ignored: got %h want 200", y_out); end
      @(negedge clk);
      coef_we    = 1'b1;
      coef_addr  = '0;
      coef_wdata = 32'h500;
      @(negedge clk);
      coef_we   = 1'b0;
      m_coef[0] = 32'h500;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (func_done !== 1'b1 || busy !== 1'b0 || y_out !== 64'h200) bad++;
      end
      n_run++;
      if (bad != 0) begin
         n_fail++; $display("FAIL done_hold: %0d bad cycles, last y=%h done=%b want 0 bad", bad, y_out, func_done);
      end
      start_func = 1'b0;
      @(negedge clk);
      do_eval(32'h200, y, ovf, lat);
      n_run++;
      if (y !== 64'h700) begin n_fail++; $display("FAIL done_write_stored: got %h want 700", y); end
   endtask

   task automatic test_accept_write();
      logic [OUT_W-1:0] y, ey;
      logic ovf, eovf;
      logic [COEF_W-1:0] newc;
      int lat;
      for (int k = 0; k <= DEG; k++) wr(k, $urandom_range(0, 32'h3FF));
      model(32'h180, ey, eovf);
      newc = $urandom_range(32'h400, 32'hFFF);
      @(negedge clk);
      start_func = 1'b1;
      x_in       = 32'h180;
      coef_we    = 1'b1;
      coef_addr  = AW'(DEG);
      coef_wdata = newc;
      @(negedge clk);
      coef_we = 1'b0;
      wait_done(lat);
      n_run++;
      if (y_out !== ey) begin n_fail++; $display("FAIL accept_write_old: got %h want %h", y_out, ey); end
      start_func = 1'b0;
      @(negedge clk);
      m_coef[DEG] = newc;
      model(32'h180, ey, eovf);
      do_eval(32'h180, y, ovf, lat);
      n_run++;
      if (y !== ey) begin n_fail++; $display("FAIL accept_write_stored: got %h want %h", y, ey); end
   endtask

   task automatic test_sweep();
      logic [OUT_W-1:0] y, ey;
      logic ovf, eovf;
      logic signed [COEF_W-1:0] v;
      int lat;
      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k <= DEG; k++) begin
            v = $urandom();
            v = v >>> $urandom_range(4, 24);
            wr(k, v);
         end
         for (int a = DEG + 1; a < (1 << AW); a++) wr(a, $urandom());
         model(DATA_W'(r * 32'h40), ey, eovf);
         do_eval(DATA_W'(r * 32'h40), y, ovf, lat);
         n_run++;
         if (y !== ey) begin n_fail++; $display("FAIL sweep_y[%0d]: got %h want %h", r, y, ey); end
         n_run++;
         if (ovf !== eovf) begin n_fail++; $display("FAIL sweep_ovf[%0d]: got %b want %b", r, ovf, eovf); end
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      start_func = 1'b0;
      x_in       = '0;
      coef_we    = 1'b0;
      coef_addr  = '0;
      coef_wdata = '0;
      for (int k = 0; k <= DEG; k++) m_coef[k] = '0;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_basic();
      test_negative();
      test_overflow();
      test_abort();
      test_coef_write();
      test_accept_write();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/poly_horner_eval.md
Name: poly_horner_eval

Overview:
Parametrised fixed-point polynomial evaluator. Computes y = c[DEG]·x^DEG + … + c[1]·x + c[0] by Horner's rule, one multiply-accumulate per cycle.
Coefficients are loaded at run time through a write port, replacing the hard-wired default polynomial of the previous generation.
Keeps the existing start_func/func_done level handshake and the Q-format conventions: input Q(DATA_W-FRAC_W).FRAC_W, output Q(OUT_W-FRAC_W).FRAC_W.

Parameters:
- DATA_W, 32: width of x_in, signed, FRAC_W fractional bits.
- COEF_W, 32: width of each coefficient, signed, FRAC_W fractional bits.
- OUT_W, 64: width of accumulator and y_out, signed, FRAC_W fractional bits.
- FRAC_W, 8: fractional bits shared by all operands.
- DEG, 4: polynomial degree (≥1). DEG+1 coefficients.
- AW, $clog2(DEG+1): coefficient address width (derived).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_func  in  1  level request; held high until func_done, then dropped.
- x_in  in  DATA_W  signed operand, sampled when a request is accepted.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  AW  coefficient index k (0..DEG).
- coef_wdata  in  COEF_W  signed coefficient value.
- y_out  out  OUT_W  signed result; holds last result.
- func_done  out  1  result valid, high in DONE state.
- busy  out  1  high in CALC state.
- overflow  out  1  overflow occurred during the last evaluation; valid with func_done.

Behaviour:
- Reset (async, rst_n low): state=IDLE; y_out=0, func_done=0, busy=0, overflow=0; all coefficients=0; x register and acc=0.
- States:
  - IDLE: on a clock edge with start_func=1: latch x_in, acc←sext(c[DEG]), cnt←DEG-1, clear overflow, go CALC.
  - CALC: each edge performs acc←step(acc, x, c[cnt]) and decrements cnt. The step with cnt=0 also loads y_out←new acc and goes DONE.
  - DONE: func_done=1. Stay while start_func=1. When start_func=0: go IDLE and drop func_done on that edge.
- Latency: the sampling edge is edge 0; func_done is high after edge DEG. y_out is stable from then until the next DONE entry.
- Holding start_func high in DONE never triggers a re-evaluation. A new request requires start_func low for at least one edge.
- Step arithmetic:
  - p = acc(OUT_W) × sext(x)(DATA_W), full OUT_W+DATA_W signed product.
  - ps = p >>> FRAC_W (arithmetic shift, truncate toward −∞).
  - s = ps + sext(c[cnt]), computed in OUT_W+DATA_W+1 bits.
  - Overflow if s does not fit in signed OUT_W. Overflow is sticky for the evaluation.
- Coefficient writes:
  - Accepted in IDLE and DONE only: c[coef_addr]←coef_wdata on the edge.
  - Ignored in CALC.
  - coef_addr > DEG is ignored.
  - A write in the same edge as request acceptance is stored, but the evaluation uses the pre-write c[DEG].
- Reset mid-operation aborts immediately; no partial result appears on y_out.

Optional Feature:
POLY_SAT_EN:
- Defined: each overflowing step result saturates to 2^(OUT_W-1)-1 or -2^(OUT_W-1) according to the sign of s, and later steps continue from the saturated value.
- Undefined: the step result wraps (keeps the low OUT_W bits).
- The overflow flag behaves identically in both builds.

Decomposition:
- Package poly_pkg:
  - state enum {IDLE, CALC, DONE};
  - functions sat_fn and sext helpers;
  - constant ONE = 1<<FRAC_W, used by the bench.
- One sub-module, poly_mac_step: a purely combinational Horner step with inputs acc, x, coef and outputs next_acc, ovf; it contains the POLY_SAT_EN logic.
- The FSM, coefficient register file and handshake stay in the top.

Test Plan:
- c0=0x100, c1=0x200, others 0, x=0x40 → y_out=0x180 (1.5), overflow=0, func_done high exactly 4 edges after the sampling edge.
- Only c2=0x100, x=0xFFFFFE00 (−2.0) → y_out=0x400 (4.0). Only c1=0x100, x=0xFFFFFF80 (−0.5) → y_out=0xFFFF_FFFF_FFFF_FF80.
- c4=0x7FFFFF00, other coefficients 0, x=0x7FFFFF00 → overflow=1. With POLY_SAT_EN: y_out=0x7FFF_FFFF_FFFF_FFFF. Without POLY_SAT_EN: y_out matches a wrapping reference model.
- rst_n pulsed low at the 2nd CALC edge → all outputs 0 asynchronously. A following evaluation with all coefficients 0 returns y_out=0.
- Write c0=0x500 during CALC → ignored, result unchanged. The same write in DONE → stored, and the next evaluation adds 5.0. start_func held high 10 cycles in DONE → no re-evaluation, y_out stable.
- Sweep x from 0 in steps of 0x40 for 10 requests with random coefficients → every y_out and overflow match the bit-accurate reference model.
